// File: rtl/if_fetch_pkg.sv
// Shared core definitions for the fetch stage: instruction width, the
// bubble instruction and the records carried through the fetch FIFOs.
package if_fetch_pkg;

    localparam int INSTR_W = 32;

    // Instruction word presented in IF/ID when no instruction is available.
    localparam logic [INSTR_W-1:0] RESET_NOP = 32'h0000_0013;

    // One fetched instruction as it travels from imem to IF/ID.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
        logic               misalign;
    } fetch_entry_t;

    // Tag remembered for every request still waiting for its response.
    typedef struct packed {
        logic [31:0] pc;
        logic        misalign;
    } fetch_tag_t;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry in-order FIFO used both as the request tag queue and as the
// instruction buffer. Push and pop may happen in the same cycle; clr wins
// over both. Callers never push when full or pop when empty.
module fetch_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_reg [2];
    logic         rd_ptr_reg;
    logic         wr_ptr_reg;
    logic [1:0]   count_reg;
    logic [1:0]   count_next;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and occupancy state; a clear empties the FIFO in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (clr) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues imem requests for pc_i, matches in-order
// responses with their PCs, buffers up to two instructions while IF/ID is
// stalled and discards responses belonging to fetches killed by a flush.
module if_fetch #(
    parameter logic [31:0] RESET_NOP = if_fetch_pkg::RESET_NOP,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    output logic [31:0] pre_pc,
    output logic        fetch_stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        hazard_ifidStall,
    input  logic        hazard_ifidFlush,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_misalign
);

    import if_fetch_pkg::*;

    localparam logic [1:0] MAX_OUTST_L = 2'(MAX_OUTST);

    logic [1:0]   tag_count;
    logic [1:0]   buf_count;
    logic [2:0]   occupancy;
    fetch_tag_t   tag_in;
    fetch_tag_t   tag_head;
    fetch_entry_t buf_head;
    fetch_entry_t resp_entry;

    logic req_valid;
    logic accept;
    logic resp_fire;
    logic resp_live;
    logic bypass;
    logic buf_push;
    logic buf_pop;

    logic [1:0]  kill_reg;
    logic [1:0]  kill_next;
    logic        first_cycle_reg;

    logic        if_id_valid_reg;
    logic        if_id_valid_next;
    logic [31:0] if_id_pc_reg;
    logic [31:0] if_id_pc_next;
    logic [31:0] if_id_instr_reg;
    logic [31:0] if_id_instr_next;
    logic        if_id_misalign_reg;
    logic        if_id_misalign_next;

    assign occupancy = {1'b0, tag_count} + {1'b0, buf_count};

    // Request issue, response classification and buffer control.
    always_comb begin
        // Never request more than there is room to hold in tags plus buffer.
        req_valid  = !reset && !hazard_ifidFlush
                     && (tag_count < MAX_OUTST_L) && (occupancy < 3'd2);
        accept     = req_valid && imem_req_ready;
        tag_in     = '{pc: pc_i, misalign: is_misaligned(pc_i)};
        // Responses with no matching tag, or right after reset, are dropped.
        resp_fire  = imem_resp_valid && !first_cycle_reg && (tag_count != 2'd0);
        resp_live  = resp_fire && (kill_reg == 2'd0) && !hazard_ifidFlush;
        resp_entry = '{pc: tag_head.pc, instr: imem_resp_data, misalign: tag_head.misalign};
        bypass     = resp_live && !hazard_ifidStall && (buf_count == 2'd0);
        buf_push   = resp_live && !bypass;
        buf_pop    = !hazard_ifidFlush && !hazard_ifidStall && (buf_count != 2'd0);
    end

    // Kill counter: on flush, every request still in flight becomes stale.
    always_comb begin
        kill_next = kill_reg;
        if (hazard_ifidFlush) begin
            kill_next = tag_count - {1'b0, resp_fire};
        end else if (resp_fire && (kill_reg != 2'd0)) begin
            kill_next = kill_reg - 2'd1;
        end
    end

    // IF/ID next value: flush bubble, buffer head, bypassed response or bubble.
    always_comb begin
        if_id_valid_next    = if_id_valid_reg;
        if_id_pc_next       = if_id_pc_reg;
        if_id_instr_next    = if_id_instr_reg;
        if_id_misalign_next = if_id_misalign_reg;
        if (hazard_ifidFlush || (!hazard_ifidStall && !buf_pop && !bypass)) begin
            if_id_valid_next    = 1'b0;
            if_id_pc_next       = 32'h0;
            if_id_instr_next    = RESET_NOP;
            if_id_misalign_next = 1'b0;
        end else if (buf_pop) begin
            if_id_valid_next    = 1'b1;
            if_id_pc_next       = buf_head.pc;
            if_id_instr_next    = buf_head.instr;
            if_id_misalign_next = buf_head.misalign;
        end else if (bypass) begin
            if_id_valid_next    = 1'b1;
            if_id_pc_next       = resp_entry.pc;
            if_id_instr_next    = resp_entry.instr;
            if_id_misalign_next = resp_entry.misalign;
        end
    end

    // Stage state: kill counter, post-reset marker and the IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kill_reg           <= 2'd0;
            first_cycle_reg    <= 1'b1;
            if_id_valid_reg    <= 1'b0;
            if_id_pc_reg       <= 32'h0;
            if_id_instr_reg    <= RESET_NOP;
            if_id_misalign_reg <= 1'b0;
        end else begin
            kill_reg           <= kill_next;
            first_cycle_reg    <= 1'b0;
            if_id_valid_reg    <= if_id_valid_next;
            if_id_pc_reg       <= if_id_pc_next;
            if_id_instr_reg    <= if_id_instr_next;
            if_id_misalign_reg <= if_id_misalign_next;
        end
    end

    fetch_fifo2 #(
        .W($bits(fetch_tag_t))
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (1'b0),
        .push      (accept),
        .push_data (tag_in),
        .pop       (resp_fire),
        .head      (tag_head),
        .count     (tag_count)
    );

    fetch_fifo2 #(
        .W($bits(fetch_entry_t))
    ) u_instr_buf (
        .clk       (clk),
        .reset     (reset),
        .clr       (hazard_ifidFlush),
        .push      (buf_push),
        .push_data (resp_entry),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    assign pre_pc         = pc_i + 32'h4;
    assign imem_req_addr  = {pc_i[31:2], 2'b00};
    assign imem_req_valid = req_valid;
    assign fetch_stall    = !(req_valid && imem_req_ready);
    assign if_id_valid    = if_id_valid_reg;
    assign if_id_pc       = if_id_pc_reg;
    assign if_id_instr    = if_id_instr_reg;
    assign if_id_misalign = if_id_misalign_reg;

    // Tags plus buffered instructions never exceed two.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        occupancy <= 3'd2);

    // A response must always have an outstanding request to match.
    a_resp_has_tag: assert property (@(posedge clk) disable iff (reset)
        !(imem_resp_valid && !first_cycle_reg && (tag_count == 2'd0)));

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_NOP, default 32'h0000_0013, meaning the instruction word presented in a bubble.
REQ-002 SHALL have parameter MAX_OUTST, default 2, meaning the maximum number of imem requests in flight; legal values are 1 and 2.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port pc_i, input, 32 bits: current PC from the PC generator.
REQ-006 SHALL have port pre_pc, output, 32 bits: sequential next PC returned to the PC generator.
REQ-007 SHALL have port fetch_stall, output, 1 bit: high when the request for pc_i was not accepted this cycle; ORed into the PC stall.
REQ-008 SHALL have ports imem_req_valid (output, 1), imem_req_ready (input, 1) and imem_req_addr (output, 32): the request channel.
REQ-009 SHALL have ports imem_resp_valid (input, 1) and imem_resp_data (input, 32): the response channel, returned in order, with no back-pressure.
REQ-010 SHALL have ports hazard_ifidStall (input, 1) and hazard_ifidFlush (input, 1): hold IF/ID, and kill younger fetches.
REQ-011 SHALL have ports if_id_valid (output, 1), if_id_pc (output, 32), if_id_instr (output, 32) and if_id_misalign (output, 1): the IF/ID register.

Function
REQ-012 SHALL drive pre_pc = pc_i + 32'h4, combinationally, with wrap modulo 2^32.
REQ-013 SHALL drive imem_req_addr = {pc_i[31:2], 2'b00}; a request SHALL be accepted only when valid and ready are both high on a clock edge.
REQ-014 SHALL assert imem_req_valid only when all of the following hold: not in reset, hazard_ifidFlush = 0, the outstanding count < MAX_OUTST, and outstanding count + buffer occupancy < 2.
REQ-015 SHALL drive fetch_stall = !(imem_req_valid && imem_req_ready).
- The PC advances only on acceptance.
- Each PC is fetched exactly once.
REQ-016 On each acceptance, SHALL push {pc_i, pc_i[1:0] != 0} into a 2-entry in-order tag FIFO.
REQ-017 On each imem_resp_valid, SHALL pop the tag FIFO.
- If the kill counter is 0: push {tag.pc, imem_resp_data, tag.misalign} into a 2-entry instruction buffer.
- Otherwise: decrement the kill counter and discard the response.
REQ-018 When hazard_ifidStall = 0, SHALL load the IF/ID register from the buffer head (valid = 1) and pop it.
- If the buffer is empty and a live response arrives in the same cycle, it SHALL bypass straight into IF/ID.
- Otherwise IF/ID SHALL load a bubble: valid = 0, instr = RESET_NOP, pc = 0, misalign = 0.
REQ-019 When hazard_ifidStall = 1, SHALL hold IF/ID unchanged; live responses SHALL be stored in the buffer.
REQ-020 On hazard_ifidFlush = 1, at the next edge SHALL:
- clear the buffer;
- load an IF/ID bubble;
- set the kill counter to (outstanding count after this cycle's responses).
- Flush SHALL override stall.
REQ-021 When a response arrives in the flush cycle, SHALL discard it and exclude it from the kill count.
REQ-022 SHALL treat the sum of the tag FIFO and buffer occupancy as never exceeding 2; overflow is unreachable by REQ-014 and SHALL be flagged by an assertion.
REQ-023 SHALL flag a response while the tag FIFO is empty as a protocol error (assertion), with no state change.
REQ-024 SHALL add latency of one clock from response to IF/ID when IF/ID is not stalled.

Reset
REQ-025 On reset, SHALL clear the tag FIFO, the buffer and the kill counter.
REQ-026 On reset, SHALL set if_id_valid = 0, if_id_instr = RESET_NOP, if_id_pc = 0 and if_id_misalign = 0.
REQ-027 During reset, imem_req_valid SHALL be 0 and fetch_stall SHALL be 1.
REQ-028 Responses arriving in the first cycle after reset release SHALL be ignored.

Structure
REQ-029 SHALL place RESET_NOP, the instruction width (32) and the fetch-entry record type {pc, instr, misalign} in the shared core package.
REQ-030 SHALL use one sub-module, fetch_fifo2, a parameterised 2-entry FIFO, instantiated for both the tag FIFO and the instruction buffer.

Verification
REQ-031 Case: pc_i=0x100, ready=1, response data 0xDEADBEEF one cycle later. Required: IF/ID = {1, 0x100, 0xDEADBEEF} on the following cycle, and pre_pc = 0x104.
REQ-032 Case: ready=0 for 3 cycles. Required: fetch_stall = 1 for 3 cycles, exactly one request for the held pc_i afterwards, and no duplicate IF/ID entry.
REQ-033 Case: two requests in flight (0x200, 0x204), then flush. Required: both responses discarded, IF/ID a bubble, the next fetch of 0x300 reaches IF/ID with no stale data.
REQ-034 Case: hazard_ifidStall held 4 cycles with 2 responses arriving. Required: IF/ID holds, the buffer reaches 2 entries, requests stop, and the entries drain in order after release.
REQ-035 Case: pc_i=0x102. Required: address 0x100, if_id_misalign = 1.
- Case: pc_i=0xFFFFFFFC. Required: pre_pc = 0x0.
REQ-036 Case: reset asserted with one request in flight. Required: all outputs at reset values, and the late response is ignored.
